fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a show-ahead FIFO and serialises them LSB first as UART frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int NB_WORD     = 8,
   parameter int N_TICK_BIT  = 16,
   parameter int N_TICK_STOP = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_tick,
   input  logic [NB_WORD-1:0] i_fifo_data,
   input  logic               i_fifo_empty,
   output logic               o_fifo_read,
   output logic               o_tx,
   output logic               o_tx_busy,
   output logic               o_tx_done
);

   localparam int N_TICK_MAX = (N_TICK_BIT > N_TICK_STOP) ? N_TICK_BIT : N_TICK_STOP;
   localparam int TW = $clog2(N_TICK_MAX + 1);
   localparam int BW = $clog2(NB_WORD + 1);
   localparam logic [TW-1:0] TICK_BIT_LAST  = TW'(N_TICK_BIT - 1);
   localparam logic [TW-1:0] TICK_STOP_LAST = TW'(N_TICK_STOP - 1);
   localparam logic [BW-1:0] BIT_LAST       = BW'(NB_WORD - 1);

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [NB_WORD-1:0] word);
      even_parity = ^word;
   endfunction

   logic parity_q, parity_d;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } state_t;
`endif

   state_t               state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [NB_WORD-1:0]   shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 read_q, read_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 tick_last_s;
   logic                 step_s;

   // State, counters, shift register and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         tick_q   <= {TW{1'b0}};
         bit_q    <= {BW{1'b0}};
         shift_q  <= {NB_WORD{1'b0}};
         tx_q     <= 1'b1;
         read_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         read_q   <= read_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next-state logic; output values are computed for the state being entered.
   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      read_d   = 1'b0;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      tick_last_s = (state_q == ST_STOP) ? (tick_q == TICK_STOP_LAST) : (tick_q == TICK_BIT_LAST);
      step_s      = i_tick && tick_last_s;
      if (i_tick) begin
         tick_d = tick_last_s ? {TW{1'b0}} : tick_q + TW'(1);
      end else begin
         tick_d = tick_q;
      end

      case (state_q)
         ST_IDLE: begin
            tick_d = {TW{1'b0}};
            bit_d  = {BW{1'b0}};
            tx_d   = 1'b1;
            // The o_tx_done cycle counts as the idle gap, so no pop is taken in it.
            if (!i_fifo_empty && !done_q) begin
               shift_d  = i_fifo_data;
               read_d   = 1'b1;
               busy_d   = 1'b1;
               tx_d     = 1'b0;
               state_d  = ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_d = even_parity(i_fifo_data);
`endif
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_START: begin
            if (step_s) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (step_s) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d   = {BW{1'b0}};
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + BW'(1);
                  tx_d  = shift_d[0];
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         ST_PARITY: begin
            if (step_s) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end else begin
               state_d = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (step_s) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
               done_d  = 1'b1;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tick_d  = {TW{1'b0}};
            bit_d   = {BW{1'b0}};
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign o_fifo_read = read_q;
   assign o_tx        = tx_q;
   assign o_tx_busy   = busy_q;
   assign o_tx_done   = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue-backed FIFO, a tick every 4 cycles and a frame decoder.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
   localparam int FLEN  = 176;
`else
   localparam int NBITS = 10;
   localparam int FLEN  = 160;
`endif

   logic       clk;
   logic       i_rst;
   logic       i_tick;
   logic [7:0] i_fifo_data;
   logic       i_fifo_empty;
   logic       o_fifo_read;
   logic       o_tx;
   logic       o_tx_busy;
   logic       o_tx_done;

   logic [7:0]  fifo[$];
   logic [7:0]  rx_q[$];
   int          len_q[$];
   logic [10:0] samp_q[$];
   logic [10:0] samp;
   int          pops, frames_seen, idle_bad, tick_idx, nbit, phase;
   bit          in_frame, saw_idle, tick_en;
   int          n_tests, n_fail;

   fifo_uart_tx #(.NB_WORD(8), .N_TICK_BIT(16), .N_TICK_STOP(16)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_tick      (i_tick),
      .i_fifo_data (i_fifo_data),
      .i_fifo_empty(i_fifo_empty),
      .o_fifo_read (o_fifo_read),
      .o_tx        (o_tx),
      .o_tx_busy   (o_tx_busy),
      .o_tx_done   (o_tx_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void fifo_update();
      i_fifo_empty = (fifo.size() == 0);
      i_fifo_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_frames(input int n);
      int cyc = 0;
      while (rx_q.size() < n && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("frame_timeout", 32'(rx_q.size() >= n), 32'd1);
   endtask

   task automatic wait_tick(input int idx);
      int cyc = 0;
      while (!(in_frame && tick_idx == idx) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("tick_timeout", 32'(in_frame && tick_idx == idx), 32'd1);
   endtask

   // Tick strobe: one cycle high every fourth cycle while enabled.
   initial begin
      phase = 0;
      forever begin
         @(posedge clk);
         #1;
         i_tick = tick_en && (phase == 3);
         phase  = (phase + 1) % 4;
      end
   end

   // Monitor: FIFO pop model plus frame decoder sampling the middle of each bit.
   initial begin
      forever begin
         @(negedge clk);
         if (i_rst) begin
            in_frame = 1'b0;
         end else begin
            if (!o_tx_busy) saw_idle = 1'b1;
            if (o_fifo_read) begin
               pops++;
               if (frames_seen > 0 && !saw_idle) idle_bad++;
               saw_idle = 1'b0;
               in_frame = 1'b1;
               tick_idx = 0;
               nbit     = 0;
               samp     = 11'h7FF;
               if (fifo.size() > 0) void'(fifo.pop_front());
               fifo_update();
            end
            if (o_tx_done && in_frame) begin
               in_frame = 1'b0;
               rx_q.push_back(samp[8:1]);
               len_q.push_back(tick_idx);
               samp_q.push_back(samp);
               frames_seen++;
            end else if (in_frame && i_tick) begin
               tick_idx++;
               if (tick_idx % 16 == 8 && nbit < NBITS) begin
                  samp[nbit] = o_tx;
                  nbit++;
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int chg;
      int ti0;
      logic tx0;
      logic [10:0] exp_a5;
      n_tests = 0; n_fail = 0; pops = 0; frames_seen = 0; idle_bad = 0;
      tick_idx = 0; nbit = 0; in_frame = 1'b0; saw_idle = 1'b1; samp = 11'h7FF;
      i_rst = 1'b1; i_tick = 1'b0; tick_en = 1'b1;
      fifo_update();

      repeat (3) @(negedge clk);
      check("rst_tx", o_tx, 1'b1);
      check("rst_busy", o_tx_busy, 1'b0);
      check("rst_done", o_tx_done, 1'b0);
      check("rst_read", o_fifo_read, 1'b0);
      i_rst = 1'b0;

      // Empty FIFO: line idle, no pops.
      bad = 0;
      repeat (500) begin
         @(negedge clk);
         if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_fifo_read !== 1'b0) bad++;
      end
      check("idle_window", bad, 0);
      check("idle_pops", pops, 0);

      // Single frame 8'hA5.
      fifo.push_back(8'hA5); fifo_update();
      wait_frames(1);
`ifdef FIFO_UART_TX_PARITY_EN
      exp_a5 = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
      exp_a5 = {1'b1, 1'b1, 8'hA5, 1'b0};
`endif
      check("a5_byte", rx_q[0], 8'hA5);
      check("a5_bits", samp_q[0], exp_a5);
      check("a5_len", len_q[0], FLEN);
      check("a5_pops", pops, 1);

      // Three back-to-back frames.
      fifo.push_back(8'h01); fifo.push_back(8'hFF); fifo.push_back(8'h3C); fifo_update();
      wait_frames(4);
      check("b2b_byte0", rx_q[1], 8'h01);
      check("b2b_byte1", rx_q[2], 8'hFF);
      check("b2b_byte2", rx_q[3], 8'h3C);
      check("b2b_len", len_q[3], FLEN);
      check("b2b_pops", pops, 4);
      check("b2b_idle_gap", idle_bad, 0);

      // Reset during data bit 3 of 8'h55, then 8'hC3 must go out intact.
      fifo.push_back(8'h55); fifo.push_back(8'hC3); fifo_update();
      wait_tick(72);
      check("pre_rst_tx", o_tx, 1'b0);
      i_rst = 1'b1;
      #1;
      check("mid_rst_tx", o_tx, 1'b1);
      check("mid_rst_busy", o_tx_busy, 1'b0);
      repeat (3) @(negedge clk);
      check("mid_rst_pops", pops, 5);
      i_rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_first_pop", pops, 6);
      wait_frames(5);
      check("post_rst_byte", rx_q[4], 8'hC3);
      check("post_rst_len", len_q[4], FLEN);

      // Tick starvation mid-frame freezes everything.
      fifo.push_back(8'h96); fifo_update();
      wait_tick(50);
      tick_en = 1'b0;
      @(negedge clk);
      tx0 = o_tx;
      ti0 = tick_idx;
      chg = 0;
      repeat (1000) begin
         @(negedge clk);
         if (o_tx !== tx0 || o_tx_busy !== 1'b1 || tick_idx != ti0 || o_fifo_read !== 1'b0) chg++;
      end
      check("freeze_stable", chg, 0);
      check("freeze_tx", tx0, 1'b1);
      tick_en = 1'b1;
      wait_frames(6);
      check("freeze_byte", rx_q[5], 8'h96);
      check("freeze_len", len_q[5], FLEN);
      check("freeze_pops", pops, 7);

`ifdef FIFO_UART_TX_PARITY_EN
      fifo.push_back(8'h07); fifo.push_back(8'h03); fifo_update();
      wait_frames(8);
      check("par07_bit", samp_q[6][9], 1'b1);
      check("par07_len", len_q[6], 176);
      check("par03_bit", samp_q[7][9], 1'b0);
      check("par03_byte", rx_q[7], 8'h03);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
